// File: rtl/aw_arb_pkg.sv
// Shared types and constants for the AW channel arbiter.
// State encoding, AXI burst encodings and the default legal address ceiling.
package aw_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ADDR   = 2'b01,
    WAIT_B = 2'b10
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [15:0] DEFAULT_ADDR_LIMIT = 16'h3FFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping,
// returned as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic [ID_W-1:0] cand;

  // Scan from the farthest candidate down to ptr+1 so the nearest one is written last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aw_channel_arbiter.sv
// Round-robin sequencer sharing one AXI4 AW channel; holds the channel until wr_done.
// Optional range check on the winning address is enabled by AW_ARB_RANGE_CHECK_EN.
module aw_channel_arbiter
  import aw_arb_pkg::*;
#(
  parameter int                NUM_REQ    = 4,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEFAULT_ADDR_LIMIT),
  parameter int                ID_W       = $clog2(NUM_REQ)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]    req_len,
  input  logic [NUM_REQ*3-1:0]    req_size,
  input  logic [NUM_REQ*2-1:0]    req_burst,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [ADDR_W-1:0]       awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  input  logic                    wr_done,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic                    aw_err
);

`ifdef AW_ARB_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     ptr_reg, ptr_next;
  logic [ID_W-1:0]     grant_reg, grant_next;
  logic [ADDR_W-1:0]   awaddr_reg, awaddr_next;
  logic [7:0]          awlen_reg, awlen_next;
  logic [2:0]          awsize_reg, awsize_next;
  logic [1:0]          awburst_reg, awburst_next;
  logic                awvalid_reg, awvalid_next;
  logic [NUM_REQ-1:0]  ack_reg, ack_next;
  logic                err_reg, err_next;

  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [7:0]          len_arr   [NUM_REQ];
  logic [2:0]          size_arr  [NUM_REQ];
  logic [1:0]          burst_arr [NUM_REQ];

  logic [NUM_REQ-1:0]  win_onehot;
  logic [ID_W-1:0]     win_idx;
  logic                win_any;
  logic                range_err;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign len_arr[gi]   = req_len[gi*8 +: 8];
    assign size_arr[gi]  = req_size[gi*3 +: 3];
    assign burst_arr[gi] = req_burst[gi*2 +: 2];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .grant_any (win_any)
  );

  assign range_err = RANGE_EN && (addr_arr[win_idx] > ADDR_LIMIT);

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    grant_next   = grant_reg;
    awaddr_next  = awaddr_reg;
    awlen_next   = awlen_reg;
    awsize_next  = awsize_reg;
    awburst_next = awburst_reg;
    awvalid_next = awvalid_reg;
    ack_next     = '0;
    err_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_any) begin
          ack_next   = win_onehot;
          grant_next = win_idx;
          ptr_next   = win_idx;
          if (range_err) begin
            // Rejected request is acknowledged and flagged, but nothing goes out on AW.
            err_next = 1'b1;
          end else begin
            awaddr_next  = addr_arr[win_idx];
            awlen_next   = len_arr[win_idx];
            awsize_next  = size_arr[win_idx];
            awburst_next = burst_arr[win_idx];
            awvalid_next = 1'b1;
            state_next   = ADDR;
          end
        end
      end
      ADDR: begin
        if (awready) begin
          awvalid_next = 1'b0;
          awaddr_next  = '0;
          awlen_next   = '0;
          awsize_next  = '0;
          awburst_next = BURST_FIXED;
          state_next   = WAIT_B;
        end
      end
      WAIT_B: begin
        if (wr_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg   <= IDLE;
      ptr_reg     <= ID_W'(NUM_REQ - 1);
      grant_reg   <= '0;
      awaddr_reg  <= '0;
      awlen_reg   <= '0;
      awsize_reg  <= '0;
      awburst_reg <= BURST_FIXED;
      awvalid_reg <= 1'b0;
      ack_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      grant_reg   <= grant_next;
      awaddr_reg  <= awaddr_next;
      awlen_reg   <= awlen_next;
      awsize_reg  <= awsize_next;
      awburst_reg <= awburst_next;
      awvalid_reg <= awvalid_next;
      ack_reg     <= ack_next;
      err_reg     <= err_next;
    end
  end

  assign req_ack  = ack_reg;
  assign awaddr   = awaddr_reg;
  assign awlen    = awlen_reg;
  assign awsize   = awsize_reg;
  assign awburst  = awburst_reg;
  assign awvalid  = awvalid_reg;
  assign grant_id = grant_reg;
  assign busy     = (state_reg != IDLE);
  assign aw_err   = err_reg;

endmodule
